// File: rtl/ptw_mem_arbiter_if.sv
// ptw_mem_arbiter_if
//   Bundles the walker request/response pairs (ITLB "I_", DTLB "D_") and the
//   AXI-master read port ("M_") that the PTE-fetch arbiter sits between.
//   modport master : the arbiter's view. It owns the M-side request and
//                    the walker responses.
//   modport slave  : the environment's view (walkers + AXI master model).
interface ptw_mem_arbiter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                  I_REQ_VALID;
   logic [ADDR_WIDTH-1:0] I_REQ_ADDR;
   logic                  I_RESP_VALID;
   logic [DATA_WIDTH-1:0] I_RESP_DATA;
   logic                  I_ACCESS_FAULT;
   logic                  D_REQ_VALID;
   logic [ADDR_WIDTH-1:0] D_REQ_ADDR;
   logic                  D_RESP_VALID;
   logic [DATA_WIDTH-1:0] D_RESP_DATA;
   logic                  D_ACCESS_FAULT;
   logic                  M_ADDR_VALID;
   logic [ADDR_WIDTH-1:0] M_ADDR;
   logic                  M_ADDR_READY;
   logic                  M_DATA_VALID;
   logic [DATA_WIDTH-1:0] M_DATA;

   modport master (
      input  I_REQ_VALID, I_REQ_ADDR, D_REQ_VALID, D_REQ_ADDR,
      input  M_ADDR_READY, M_DATA_VALID, M_DATA,
      output I_RESP_VALID, I_RESP_DATA, I_ACCESS_FAULT,
      output D_RESP_VALID, D_RESP_DATA, D_ACCESS_FAULT,
      output M_ADDR_VALID, M_ADDR
   );

   modport slave (
      output I_REQ_VALID, I_REQ_ADDR, D_REQ_VALID, D_REQ_ADDR,
      output M_ADDR_READY, M_DATA_VALID, M_DATA,
      input  I_RESP_VALID, I_RESP_DATA, I_ACCESS_FAULT,
      input  D_RESP_VALID, D_RESP_DATA, D_ACCESS_FAULT,
      input  M_ADDR_VALID, M_ADDR
   );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter
//   Shares one AXI-master read port between the ITLB and DTLB page-table
//   walkers. Request pulses are captured into per-walker pending slots,
//   granted round-robin, and served one outstanding read at a time. Each
//   PTE is returned to its owner, or an access fault is raised when the
//   memory does not answer within TIMEOUT_CYCLES.
// Ports
//   CLK, RST_N : clock (posedge), asynchronous active-low reset
//   bus        : walker request/response + M-side read port (master view)
//   BUSY       : FSM not idle, or any walker request still pending
// Walker lanes are packed as index 0 = ITLB, 1 = DTLB.
module ptw_mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               CLK,
   input  logic               RST_N,
   ptw_mem_arbiter_if.master  bus,
   output logic               BUSY
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                         state, state_n;
   logic [1:0]                     req_vld, pend, elig, clr;
   logic [1:0][ADDR_WIDTH-1:0]     req_addr, addr_q;
   logic [1:0]                     resp_vld, fault;
   logic [1:0][DATA_WIDTH-1:0]     resp_data;
   logic                           owner, last_grant;
   logic [CW-1:0]                  cnt;
   logic                           m_addr_valid;
   logic [ADDR_WIDTH-1:0]          m_addr;
   logic                           grant_vld, grant_id, done, tmo;
   logic [ADDR_WIDTH-1:0]          grant_addr;

   assign req_vld  = {bus.D_REQ_VALID, bus.I_REQ_VALID};
   assign req_addr = {bus.D_REQ_ADDR,  bus.I_REQ_ADDR};
   // A pulse in the grant cycle is eligible straight away (bypass).
   assign elig     = pend | req_vld;

   always_comb begin
      state_n    = state;
      grant_vld  = 1'b0;
      grant_id   = 1'b0;
      grant_addr = '0;
      done       = 1'b0;
      tmo        = 1'b0;
      clr        = '0;
      case (state)
         S_IDLE: begin
            if (|elig) begin
               grant_vld  = 1'b1;
               // Round-robin only arbitrates ties; a lone requester just wins.
               grant_id   = (&elig) ? ~last_grant : elig[1];
               grant_addr = pend[grant_id] ? addr_q[grant_id] : req_addr[grant_id];
               state_n    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus.M_ADDR_READY) state_n = S_WAIT;
         end
         S_WAIT: begin
            // Data beats the timeout when both land in the same cycle.
            if (bus.M_DATA_VALID) begin
               done    = 1'b1;
               state_n = S_IDLE;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               tmo     = 1'b1;
               state_n = S_IDLE;
            end
            clr[owner] = done | tmo;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= S_IDLE;
         pend         <= '0;
         addr_q       <= '0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
         cnt          <= '0;
         m_addr_valid <= 1'b0;
         m_addr       <= '0;
         resp_vld     <= '0;
         resp_data    <= '0;
         fault        <= '0;
      end else begin
         state    <= state_n;
         resp_vld <= '0;
         fault    <= '0;
         // A repeat pulse while already pending is dropped; first address kept.
         for (int x = 0; x < 2; x++) begin
            if (req_vld[x] && !pend[x]) addr_q[x] <= req_addr[x];
            pend[x] <= (pend[x] & ~clr[x]) | (req_vld[x] & ~pend[x]);
         end
         if (grant_vld) begin
            owner        <= grant_id;
            m_addr       <= grant_addr;
            m_addr_valid <= 1'b1;
            if (&elig) last_grant <= grant_id;
         end
         if (state == S_ADDR && bus.M_ADDR_READY) begin
            m_addr_valid <= 1'b0;
            cnt          <= '0;
         end
         if (state == S_WAIT && !done && !tmo) cnt <= cnt + CW'(1);
         if (done) begin
            resp_vld[owner]  <= 1'b1;
            resp_data[owner] <= bus.M_DATA;
         end
         if (tmo) fault[owner] <= 1'b1;
         // Illegal encoding: drop any stale request while recovering to IDLE.
         if (state != S_IDLE && state != S_ADDR && state != S_WAIT)
            m_addr_valid <= 1'b0;
      end
   end

   assign bus.M_ADDR_VALID   = m_addr_valid;
   assign bus.M_ADDR         = m_addr;
   assign bus.I_RESP_VALID   = resp_vld[0];
   assign bus.I_RESP_DATA    = resp_data[0];
   assign bus.I_ACCESS_FAULT = fault[0];
   assign bus.D_RESP_VALID   = resp_vld[1];
   assign bus.D_RESP_DATA    = resp_data[1];
   assign bus.D_ACCESS_FAULT = fault[1];
   assign BUSY               = (state != S_IDLE) | (|pend);
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter
//   Directed bench for ptw_mem_arbiter (TIMEOUT_CYCLES=8). Expected walker
//   responses are queued when read data / timeouts are provoked and popped by
//   a negedge monitor whenever a response or fault pulse appears.
module tb_ptw_mem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;
   // Pulse vector {I_RESP_VALID, I_ACCESS_FAULT, D_RESP_VALID, D_ACCESS_FAULT}
   localparam logic [3:0] V_IR = 4'b1000;
   localparam logic [3:0] V_DR = 4'b0010;
   localparam logic [3:0] V_DF = 4'b0001;

   logic CLK = 1'b0;
   logic RST_N;
   logic BUSY;
   always #5 CLK = ~CLK;

   ptw_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ptw_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.master),
      .BUSY  (BUSY)
   );

   typedef struct {
      logic [3:0]    vec;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [3:0] pv;
   assign pv = {bus.I_RESP_VALID, bus.I_ACCESS_FAULT, bus.D_RESP_VALID, bus.D_ACCESS_FAULT};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic req(input logic iv, input logic [AW-1:0] ia, input logic dv, input logic [AW-1:0] da);
      bus.I_REQ_VALID = iv; bus.I_REQ_ADDR = ia;
      bus.D_REQ_VALID = dv; bus.D_REQ_ADDR = da;
      step(1);
      bus.I_REQ_VALID = 1'b0; bus.D_REQ_VALID = 1'b0;
   endtask

   task automatic await_grant(input string tag, input logic [AW-1:0] addr);
      int n = 0;
      while (!bus.M_ADDR_VALID && n < 20) begin step(1); n++; end
      check({tag, "_mvalid"}, bus.M_ADDR_VALID, 1);
      check({tag, "_maddr"}, bus.M_ADDR, addr);
   endtask

   task automatic handshake(input string tag, input int stall);
      logic [AW-1:0] a0;
      a0 = bus.M_ADDR;
      for (int k = 0; k < stall; k++) begin
         step(1);
         check({tag, "_stall_valid"}, bus.M_ADDR_VALID, 1);
         check({tag, "_stall_addr"}, bus.M_ADDR, a0);
      end
      bus.M_ADDR_READY = 1'b1;
      step(1);
      bus.M_ADDR_READY = 1'b0;
      check({tag, "_mvalid_drop"}, bus.M_ADDR_VALID, 0);
   endtask

   task automatic give_data(input logic [3:0] vec, input logic [DW-1:0] d, input int delay);
      if (delay > 0) step(delay);
      sb.push_back('{vec: vec, data: d});
      bus.M_DATA_VALID = 1'b1; bus.M_DATA = d;
      step(1);
      bus.M_DATA_VALID = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 10) begin step(1); n++; end
      check({tag, "_drained"}, 64'(sb.size()), 0);
   endtask

   // Scoreboard monitor: every response/fault pulse must match the queue head.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (RST_N === 1'b1 && pv != 4'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {60'd0, pv}, 0);
         end else begin
            e = sb.pop_front();
            check("resp_kind", {60'd0, pv}, {60'd0, e.vec});
            if (e.vec == V_IR) check("i_resp_data", bus.I_RESP_DATA, e.data);
            if (e.vec == V_DR) check("d_resp_data", bus.D_RESP_DATA, e.data);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      RST_N = 1'b0;
      bus.I_REQ_VALID = 0; bus.I_REQ_ADDR = '0;
      bus.D_REQ_VALID = 0; bus.D_REQ_ADDR = '0;
      bus.M_ADDR_READY = 0; bus.M_DATA_VALID = 0; bus.M_DATA = '0;
      #12;
      check("rst_mvalid", bus.M_ADDR_VALID, 0);
      check("rst_maddr", bus.M_ADDR, 0);
      check("rst_pulses", {60'd0, pv}, 0);
      check("rst_idata", bus.I_RESP_DATA, 0);
      check("rst_busy", BUSY, 0);
      @(negedge CLK) RST_N = 1'b1;
      step(1);

      // 1: single ITLB fetch, M_ADDR_VALID the cycle after the pulse
      check("t1_pre", bus.M_ADDR_VALID, 0);
      req(1, 64'h8000_1000, 0, 0);
      check("t1_latency", bus.M_ADDR_VALID, 1);
      check("t1_addr", bus.M_ADDR, 64'h8000_1000);
      check("t1_busy", BUSY, 1);
      handshake("t1", 0);
      give_data(V_IR, 64'hCF, 2);
      check("t1_iresp", bus.I_RESP_VALID, 1);
      check("t1_idata", bus.I_RESP_DATA, 64'hCF);
      check("t1_dresp", bus.D_RESP_VALID, 0);
      check("t1_busy_done", BUSY, 0);
      drain("t1");

      // 2: tie after reset -> I then D; second tie -> D then I
      req(1, 64'h1100, 1, 64'h2200);
      await_grant("t2a", 64'h1100);
      handshake("t2a", 0);
      give_data(V_IR, 64'h11, 1);
      await_grant("t2b", 64'h2200);
      handshake("t2b", 0);
      give_data(V_DR, 64'h22, 1);
      drain("t2ab");
      req(1, 64'h3300, 1, 64'h4400);
      await_grant("t2c", 64'h4400);
      handshake("t2c", 0);
      give_data(V_DR, 64'h33, 1);
      await_grant("t2d", 64'h3300);
      handshake("t2d", 0);
      give_data(V_IR, 64'h44, 1);
      drain("t2cd");

      // 3: address stall of 10 cycles
      req(1, 64'hA000, 0, 0);
      await_grant("t3", 64'hA000);
      handshake("t3", 10);
      give_data(V_IR, 64'h55, 0);
      drain("t3");

      // 4: DTLB timeout after 8 WAIT cycles, then a late beat is ignored
      req(0, 0, 1, 64'hB000);
      await_grant("t4", 64'hB000);
      handshake("t4", 0);
      sb.push_back('{vec: V_DF, data: '0});
      for (int k = 0; k < TO - 1; k++) begin
         step(1);
         check("t4_no_early_fault", bus.D_ACCESS_FAULT, 0);
      end
      step(1);
      check("t4_fault", bus.D_ACCESS_FAULT, 1);
      check("t4_busy", BUSY, 0);
      bus.M_DATA_VALID = 1; bus.M_DATA = 64'hDEAD;
      step(1);
      bus.M_DATA_VALID = 0;
      step(1);
      check("t4_late_pulses", {60'd0, pv}, 0);
      check("t4_late_mvalid", bus.M_ADDR_VALID, 0);
      drain("t4");

      // 5: D queued while I waits; repeat D pulse ignored; 1 bubble before D
      req(1, 64'hC000, 0, 0);
      await_grant("t5i", 64'hC000);
      handshake("t5i", 0);
      step(1);
      req(0, 0, 1, 64'hD000);
      req(0, 0, 1, 64'hD0BAD);
      give_data(V_IR, 64'h66, 1);
      check("t5_bubble", bus.M_ADDR_VALID, 0);
      check("t5_busy", BUSY, 1);
      step(1);
      check("t5_dgrant", bus.M_ADDR_VALID, 1);
      check("t5_daddr", bus.M_ADDR, 64'hD000);
      handshake("t5d", 0);
      give_data(V_DR, 64'h77, 0);
      drain("t5");

      // 6: asynchronous reset mid-WAIT, later data must not respond
      req(1, 64'hE000, 0, 0);
      await_grant("t6", 64'hE000);
      handshake("t6", 0);
      check("t6_busy_pre", BUSY, 1);
      #2 RST_N = 1'b0;
      #1;
      check("t6_busy", BUSY, 0);
      check("t6_maddr", bus.M_ADDR, 0);
      check("t6_idata", bus.I_RESP_DATA, 0);
      check("t6_ddata", bus.D_RESP_DATA, 0);
      @(negedge CLK) RST_N = 1'b1;
      step(1);
      bus.M_DATA_VALID = 1; bus.M_DATA = 64'hBAD;
      step(1);
      bus.M_DATA_VALID = 0;
      check("t6_no_resp", {60'd0, pv}, 0);
      step(2);
      check("t6_busy_post", BUSY, 0);
      drain("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
